// File: rtl/run_detect_sched_if.sv
// run_detect_sched_if: requester bus and run-flag outputs of the shared run detector.
interface run_detect_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            doutx;
  logic            douty;
  logic            dout_vld;
  logic            frame_done;
  logic            frame_abort;
  modport master (output req, din, input gnt, gnt_id, doutx, douty, dout_vld, frame_done, frame_abort);
  modport slave  (input req, din, output gnt, gnt_id, doutx, douty, dout_vld, frame_done, frame_abort);
endinterface

// File: rtl/run_detect_sched.sv
// run_detect_sched: round-robin framed sharing of one consecutive-equal-bit run detector.
module run_detect_sched #(
  parameter  int NREQ      = 4,
  parameter  int FRAME_LEN = 8,
  localparam int IDW       = $clog2(NREQ)
) (
  input logic               clk,
  input logic               resetn,
  run_detect_sched_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN) + 1;
  typedef enum logic [1:0] {ARB, RUN, DONE} state_t;
  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IDW-1:0]  gnt_id_q, ptr_q, win_d, cand;
  logic [CW-1:0]   k_q;
  logic            h1_q, h2_q, x_q, y_q, vld_q, done_q, abort_q;
  logic            b, held;
  assign b    = bus.din[gnt_id_q];
  assign held = bus.req[gnt_id_q];
  // Scan offsets high to low so the nearest requester after the pointer wins.
  always_comb begin
    win_d = ptr_q;
    cand  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      win_d = bus.req[cand] ? cand : win_d;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= ARB;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= IDW'(NREQ - 1);
      k_q      <= '0;
      h1_q     <= 1'b0;
      h2_q     <= 1'b0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      vld_q   <= 1'b0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        ARB:
          if (|bus.req) begin
            gnt_q    <= NREQ'(1) << win_d;
            gnt_id_q <= win_d;
            ptr_q    <= win_d;
            k_q      <= '0;
            h1_q     <= 1'b0;
            h2_q     <= 1'b0;
            state_q  <= RUN;
          end
        RUN:
          if (!held) begin
            gnt_q   <= '0;
            done_q  <= 1'b1;
            abort_q <= 1'b1;
            state_q <= DONE;
          end else begin
            vld_q <= 1'b1;
            x_q   <= (k_q >= CW'(1)) && (b == h1_q);
            y_q   <= (k_q >= CW'(2)) && (b == h1_q) && (h1_q == h2_q);
            h1_q  <= b;
            h2_q  <= h1_q;
            k_q   <= k_q + CW'(1);
            if (k_q == CW'(FRAME_LEN - 1)) begin
              gnt_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        default: state_q <= ARB;
      endcase
    end
  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.doutx       = x_q;
  assign bus.douty       = y_q;
  assign bus.dout_vld    = vld_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;
endmodule

// File: tb/tb_run_detect_sched.sv
// tb_run_detect_sched: directed and randomized frames checked against a run-length model.
module tb_run_detect_sched;
  localparam int N  = 4;
  localparam int FL = 8;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  int ptr_m = N - 1;
  run_detect_sched_if #(.NREQ(N)) bi ();
  run_detect_sched #(.NREQ(N), .FRAME_LEN(FL)) dut (.clk(clk), .resetn(resetn), .bus(bi.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bi.req = '0;
    bi.din = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    ptr_m = N - 1;
  endtask

  // drop_at / rst_at = slot index at which req is dropped / reset is pulsed, -1 for none
  task automatic frame(input logic [N-1:0] reqv, input logic [FL-1:0] bits,
                       input int drop_at, input int rst_at, input int exp_wait);
    int e, w, run;
    logic prev;
    e = -1;
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (ptr_m + i) % N;
      if (e < 0 && reqv[c]) e = c;
    end
    bi.req = reqv;
    bi.din = N'($urandom);
    w = 0;
    while (bi.gnt === '0 && w < 6) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    chk("gnt_latency", w, exp_wait);
    chk("gnt", bi.gnt, 32'(1) << e);
    chk("gnt_id", bi.gnt_id, e);
    if (bi.gnt !== N'(1) << e) return;
    ptr_m = e;
    run = 0;
    prev = 1'b0;
    for (int j = 0; j < FL; j++) begin
      bi.din = N'($urandom);
      bi.din[e] = bits[j];
      bi.req = reqv;
      bi.req[e] = (j != drop_at);
      if (j == rst_at) begin
        resetn = 1'b0;
        #1;
        chk("rst_gnt", bi.gnt, 0);
        chk("rst_vld", bi.dout_vld, 0);
        chk("rst_done", bi.frame_done, 0);
        @(negedge clk);
        chk("rst_hold_done", bi.frame_done, 0);
        resetn = 1'b1;
        ptr_m = N - 1;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (j == drop_at) begin
        chk("abort_vld", bi.dout_vld, 0);
        chk("abort_done", bi.frame_done, 1);
        chk("abort_flag", bi.frame_abort, 1);
        chk("abort_gnt", bi.gnt, 0);
        return;
      end
      run = (j > 0 && bits[j] == prev) ? run + 1 : 1;
      prev = bits[j];
      chk("vld", bi.dout_vld, 1);
      chk("doutx", bi.doutx, run >= 2);
      chk("douty", bi.douty, run >= 3);
      chk("done", bi.frame_done, j == FL - 1);
      chk("abort", bi.frame_abort, 0);
      chk("gnt_run", bi.gnt, (j == FL - 1) ? 0 : (32'(1) << e));
    end
  endtask

  initial begin
    bi.req = '0;
    bi.din = '0;
    do_reset();
    chk("reset_gnt", bi.gnt, 0);
    chk("reset_id", bi.gnt_id, 0);
    chk("reset_vld", bi.dout_vld, 0);
    chk("reset_done", bi.frame_done, 0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_gnt", bi.gnt, 0);
    end
    frame(4'b0001, 8'b00100111, -1, -1, 1);
    do_reset();
    frame(4'b1111, 8'h5A, -1, -1, 1);
    repeat (4) frame(4'b1111, FL'($urandom), -1, -1, 2);
    do_reset();
    frame(4'b0101, FL'($urandom), -1, -1, 1);
    repeat (3) frame(4'b0101, FL'($urandom), -1, -1, 2);
    do_reset();
    frame(4'b0110, 8'h0F, 3, -1, 1);
    frame(4'b0110, 8'hF0, -1, -1, 2);
    frame(4'b0001, 8'hFF, -1, -1, 2);
    frame(4'b0001, 8'hFF, -1, -1, 2);
    frame(4'b0100, 8'h33, -1, 4, 2);
    frame(4'b1111, 8'hC3, -1, -1, 1);
    for (int n = 0; n < 30; n++)
      frame(N'($urandom_range(1, 15)), FL'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FL - 1)) : -1, -1, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/run_detect_sched.md
Name: run_detect_sched

Overview:
Round-robin scheduler that shares one consecutive-equal-bit run detector among NREQ serial requesters. A requester holds req; the scheduler grants it a frame of FRAME_LEN bit slots. It samples that requester's din each slot and reports per-slot run flags: doutx for run length >= 2, douty for run length >= 3. The block sits between several serial bit sources and the downstream run-statistics logic.

Parameters:
NREQ, 4, number of requesters (>= 2)
FRAME_LEN, 8, bit slots per granted frame (>= 2, <= 256)
IDW, $clog2(NREQ), width of gnt_id (derived; do not override)

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
req  in  NREQ  per-requester request; level, held for the whole frame
din  in  NREQ  per-requester serial bit, valid every cycle while granted
gnt  out  NREQ  one-hot grant, registered
gnt_id  out  IDW  index of the current/last granted requester, registered
doutx  out  1  run length >= 2 at this slot, qualified by dout_vld
douty  out  1  run length >= 3 at this slot, qualified by dout_vld
dout_vld  out  1  doutx/douty valid this cycle
frame_done  out  1  one-cycle pulse at frame end
frame_abort  out  1  with frame_done: frame ended early because req dropped

Behaviour:
- Reset (resetn low, asynchronous): state ARB. All outputs 0, gnt_id 0, slot counter 0, history cleared, RR pointer = NREQ-1 so requester 0 has top priority first.
- FSM states: ARB, RUN, DONE.
- ARB: if req != 0, pick the first set req scanning upward from pointer+1 (mod NREQ). Next cycle: gnt one-hot, gnt_id = winner, pointer = winner, slot count k = 0, state RUN. If req == 0, stay in ARB with gnt = 0.
- RUN, one sample per cycle: b_k = din[gnt_id].
  - Next cycle: dout_vld = 1.
  - doutx = (k >= 1) and b_k == b_(k-1).
  - douty = (k >= 2) and b_k == b_(k-1) == b_(k-2).
  - History is per frame only and never carries across frames or requesters.
- Normal exit: after slot k = FRAME_LEN-1 is sampled, next state is DONE.
- Abort exit: if req[gnt_id] is low in a RUN cycle, that cycle's sample is not taken (no dout_vld for it). Next state is DONE with frame_abort = 1.
- req of non-granted requesters is ignored during RUN. No preemption.
- DONE lasts one cycle:
  - gnt = 0, frame_done = 1.
  - dout_vld/doutx/douty carry the final sample's result, if any.
  - Next state ARB.
- Latency: req rise in ARB -> gnt one cycle later. First dout_vld comes one cycle after gnt rises.
- Frame cadence: FRAME_LEN + 2 cycles from gnt rise to the next possible gnt rise; the gap is DONE + ARB.
- Simultaneous requests resolve by RR order. The same requester is never granted twice in a row while another requester is waiting.
- gnt_id holds its value in ARB/DONE. gnt is strictly 0 outside RUN.
- Counter width: $clog2(FRAME_LEN) + 1; no wrap inside a frame.
- Reset mid-frame: immediate return to the reset state; no frame_done is issued.

Test Plan:
- Single requester 0, FRAME_LEN=8, din[0] = 1,1,1,0,0,1,0,0 -> gnt=0001 one cycle after req; doutx = 0,1,1,0,1,0,0,1; douty = 0,0,1,0,0,0,0,0; frame_done=1, frame_abort=0 in the cycle of the 8th dout_vld.
- req=1111 held continuously -> grants in order 0,1,2,3,0, each lasting 8 cycles with a 2-cycle gap between grants.
- req=0101 from reset -> grant order 0,2,0,2; requesters 1 and 3 are never granted.
- Requester 1 granted, req[1] dropped after 3 samples -> exactly 3 dout_vld; frame_done=1 with frame_abort=1; next ARB grants 2 if it is requesting.
- Back-to-back frames to the same requester with din constant 1 -> first slot of frame 2 has doutx=0 and douty=0 (history cleared).
- resetn low for one cycle mid-RUN -> gnt, dout_vld and frame_done all 0 immediately; after release, requester 0 has top priority again.
